// File: rtl/page_table_walker_if.sv
// page_table_walker_if: MMU miss/refill and memory read handshakes of the page table walker.
interface page_table_walker_if #(
    parameter int PALEN  = 32,
    parameter int ASID_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [PALEN-1:0]  req_vaddr;
    logic [ASID_W-1:0] req_asid;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [PALEN-1:0]  mem_req_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              refill_valid;
    logic              refill_ready;
    logic [18:0]       refill_vppn;
    logic [ASID_W-1:0] refill_asid;
    logic [31:0]       refill_pte;
    logic              refill_huge;
    logic              refill_fault;
    modport master (
        output req_valid, req_vaddr, req_asid, mem_req_ready, mem_rsp_valid, mem_rsp_data, refill_ready,
        input  req_ready, mem_req_valid, mem_req_addr, refill_valid, refill_vppn, refill_asid,
               refill_pte, refill_huge, refill_fault
    );
    modport slave (
        input  req_valid, req_vaddr, req_asid, mem_req_ready, mem_rsp_valid, mem_rsp_data, refill_ready,
        output req_ready, mem_req_valid, mem_req_addr, refill_valid, refill_vppn, refill_asid,
               refill_pte, refill_huge, refill_fault
    );
endinterface

// File: rtl/page_table_walker.sv
// page_table_walker: two-level Sv32-style walker returning a TLB refill or page fault.
// Define PTW_HUGEPAGE_EN to terminate walks at level 1 on directory entries with H set.
module page_table_walker #(
    parameter int PALEN  = 32,
    parameter int ASID_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [PALEN-1:0] pgd_base,
    page_table_walker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP, DRAIN} state_t;
    state_t            state, state_n;
    logic [19:0]       vpn_q;
    logic [ASID_W-1:0] asid_q;
    logic [PALEN-1:0]  addr_q;
    logic [31:0]       pte_q;
    logic              fault_q;
    logic              huge_q;
    logic              dir_zero;
    logic              dir_huge;
    logic              rsp;
    logic              unused_pgd_offset;
    assign unused_pgd_offset = ^pgd_base[11:0];
    assign rsp      = bus.mem_rsp_valid;
    assign dir_zero = bus.mem_rsp_data == 32'h0;
`ifdef PTW_HUGEPAGE_EN
    assign dir_huge = bus.mem_rsp_data[6];
`else
    assign dir_huge = 1'b0;
`endif
    assign bus.req_ready     = state == IDLE && !flush;
    assign bus.mem_req_valid = state == L1_REQ || state == L2_REQ;
    assign bus.mem_req_addr  = addr_q;
    assign bus.refill_valid  = state == RESP;
    assign bus.refill_vppn   = vpn_q[19:1];
    assign bus.refill_asid   = asid_q;
    assign bus.refill_pte    = pte_q;
    assign bus.refill_fault  = fault_q;
    assign bus.refill_huge   = huge_q;
    // Flush wins over every transition; an accepted memory read must still be drained.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:           state_n = bus.req_valid && !flush ? L1_REQ : IDLE;
            L1_REQ, L2_REQ: state_n = bus.mem_req_ready ? (flush ? DRAIN : state == L1_REQ ? L1_WAIT : L2_WAIT)
                                                        : (flush ? IDLE : state);
            L1_WAIT:        state_n = rsp ? (flush ? IDLE : dir_zero || dir_huge ? RESP : L2_REQ)
                                          : (flush ? DRAIN : L1_WAIT);
            L2_WAIT:        state_n = rsp ? (flush ? IDLE : RESP) : (flush ? DRAIN : L2_WAIT);
            RESP:           state_n = flush || bus.refill_ready ? IDLE : RESP;
            DRAIN:          state_n = rsp ? IDLE : DRAIN;
            default:        state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vpn_q   <= '0;
            asid_q  <= '0;
            addr_q  <= '0;
            pte_q   <= '0;
            fault_q <= 1'b0;
            huge_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req_valid && !flush) begin
                vpn_q  <= bus.req_vaddr[31:12];
                asid_q <= bus.req_asid;
                addr_q <= {pgd_base[31:12], bus.req_vaddr[31:22], 2'b00};
            end
            if (state == L1_WAIT && rsp && !flush) begin
                addr_q  <= {bus.mem_rsp_data[31:12], vpn_q[9:0], 2'b00};
                pte_q   <= dir_huge ? bus.mem_rsp_data : 32'h0;
                fault_q <= dir_zero;
                huge_q  <= dir_huge;
            end
            if (state == L2_WAIT && rsp && !flush) begin
                pte_q   <= bus.mem_rsp_data[0] ? bus.mem_rsp_data : 32'h0;
                fault_q <= ~bus.mem_rsp_data[0];
                huge_q  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/page_table_walker.md
# page_table_walker

Hardware two-level page table walker for Sv32-style 4 KiB paging (10/10/12 split). It sits directly downstream of the memory management unit. On a TLB miss it takes the faulting virtual address, reads the directory entry and then the leaf PTE through a single-outstanding memory read port, and returns a refill entry or a fault. The MMU writes that result into the TLB.

## Interface
Parameters:
- PALEN, 32, physical/virtual address width (fixed 32 for this paging format)
- ASID_W, 10, ASID width carried through to the refill

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  abort the current walk (TLB invalidate / pipeline flush)
- pgd_base  in  PALEN  root page directory base; bits [11:0] are ignored
- req_valid  in  1  miss request from MMU
- req_ready  out  1  walker can accept a request
- req_vaddr  in  PALEN  faulting virtual address
- req_asid  in  ASID_W  ASID of the faulting access
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  PALEN  word-aligned read address
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read data
- refill_valid  out  1  refill result valid
- refill_ready  in  1  MMU consumes the result
- refill_vppn  out  19  req_vaddr[31:13]
- refill_asid  out  ASID_W  latched req_asid
- refill_pte  out  32  leaf entry (or huge directory entry)
- refill_huge  out  1  result maps a 4 MiB page
- refill_fault  out  1  page-invalid fault; refill_pte is then 0

## Operation
- Directory entry format:
  - [31:12] is the next-level table base.
  - bit 6 is H (huge).
  - An all-zero entry is invalid.
- Leaf format:
  - bit 0 is V, bit 1 is D, [3:2] is PLV, [5:4] is MAT, bit 6 is G.
  - [31:12] is the PPN.
- Addresses:
  - L1 address = {pgd_base[31:12], vaddr[31:22], 2'b00}.
  - L2 address = {dir[31:12], vaddr[21:12], 2'b00}.
- FSM states: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP, DRAIN.
  - IDLE: req_ready=1. On req_valid, latch vaddr, asid and pgd_base, then go to L1_REQ.
  - L1_REQ / L2_REQ: mem_req_valid=1 with the address held stable until mem_req_ready. On handshake, go to the matching _WAIT state.
  - L1_WAIT: on mem_rsp_valid, latch the data.
    - Zero entry: go to RESP with fault=1.
    - H=1 (when the Configuration feature is enabled): go to RESP with huge=1 and pte=data.
    - Otherwise: go to L2_REQ.
  - L2_WAIT: on mem_rsp_valid, latch the PTE and go to RESP. fault = ~data[0].
  - RESP: refill_valid=1, with outputs held until refill_ready, then go to IDLE.
  - DRAIN: wait for the one outstanding mem_rsp_valid, discard it, then go to IDLE. req_ready=0 in this state.
- Only one memory request is ever outstanding. mem_rsp_valid outside a _WAIT or DRAIN state is ignored.
- Flush behaviour:
  - flush in L1_REQ or L2_REQ with no handshake that cycle: go to IDLE.
  - flush in L1_REQ or L2_REQ together with a mem handshake: go to DRAIN.
  - flush in _WAIT without mem_rsp_valid: go to DRAIN.
  - flush in _WAIT with mem_rsp_valid that cycle: the response is discarded and the next state is IDLE.
  - flush in RESP: go to IDLE with no refill.
  - flush in IDLE: blocks acceptance that cycle (req_ready=0).
  - flush in DRAIN: no effect.
- Mid-operation reset: all state returns to IDLE immediately. In-flight memory responses arriving after reset deassertion are ignored.

## Timing
- Reset values:
  - req_ready=1 (IDLE).
  - mem_req_valid=0, mem_req_addr=0.
  - refill_valid=0.
  - All refill_* data outputs = 0.
- All outputs are registered or decoded from state only. No combinational path exists from req_valid to mem_req_valid, or from mem_rsp_* to refill_*.
- Accept request in cycle T:
  - mem_req_valid rises at T+1.
  - With zero-wait memory (ready=1, response the cycle after the handshake), a normal two-level walk has refill_valid at T+5.
  - A huge-page or L1-fault walk has refill_valid at T+3.
- A back-to-back request can be accepted the cycle after the refill handshake (IDLE lasts at least one cycle).

## Configuration
- PTW_HUGEPAGE_EN defined:
  - A directory entry with H=1 terminates the walk at level 1.
  - refill_huge=1 and refill_pte = directory entry.
- Not defined:
  - The H bit is ignored and every non-zero directory entry walks to level 2.
  - refill_huge is tied to 0.

## Test plan
- Normal walk:
  - Setup: pgd_base=0x0010_0000, vaddr=0x1234_5678.
  - Stimulus: L1 word 0x0020_0000 returned from 0x0010_0120, L2 word 0x0ABC_D0F3 returned from 0x0020_0D14.
  - Required: refill_valid at T+5, pte=0x0ABC_D0F3, vppn=0x091A2, fault=0.
- Zero directory entry:
  - Stimulus: L1 returns 0.
  - Required: fault=1, pte=0, no second mem_req_valid.
- Leaf with V=0:
  - Stimulus: L2 returns 0x0ABC_D0F2.
  - Required: fault=1.
- Huge page:
  - Stimulus: L1 returns 0x0040_0040.
  - With PTW_HUGEPAGE_EN: huge=1 at T+3.
  - Without it: L2 read issued at address 0x0040_0D14.
- Flush in L2_WAIT:
  - Stimulus: flush asserted, response delayed 4 cycles.
  - Required: state DRAIN, req_ready=0 until the response arrives, no refill, then req_ready=1.
- Backpressure and reset:
  - Stimulus: hold mem_req_ready=0 for 3 cycles.
  - Required: mem_req_addr stable throughout.
  - Stimulus: hold refill_ready=0.
  - Required: refill outputs stable.
  - Stimulus: assert rst during L1_WAIT.
  - Required: all outputs return to reset values immediately, and the late response is ignored.
